// File: rtl/bellek_hakem_if.sv
// Bus bundle between the two memory requesters, the arbiter and the single-port memory.
// The master side drives the requests and the memory read data; the slave side is the arbiter.
interface bellek_hakem_if #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
);
   logic                 istek0;
   logic                 istek1;
   logic [ADRES_BIT-1:0] adres0;
   logic [ADRES_BIT-1:0] adres1;
   logic                 yaz0;
   logic                 yaz1;
   logic [VERI_BIT-1:0]  yaz_veri0;
   logic [VERI_BIT-1:0]  yaz_veri1;
   logic                 kabul0;
   logic                 kabul1;
   logic                 yanit0;
   logic                 yanit1;
   logic [VERI_BIT-1:0]  oku_veri;
   logic [ADRES_BIT-1:0] bellek_adres;
   logic                 bellek_yaz;
   logic [VERI_BIT-1:0]  bellek_yaz_veri;
   logic [VERI_BIT-1:0]  bellek_oku_veri;
   logic                 mesgul;

   modport master (
      output istek0, istek1, adres0, adres1, yaz0, yaz1, yaz_veri0, yaz_veri1,
      output bellek_oku_veri,
      input  kabul0, kabul1, yanit0, yanit1, oku_veri,
      input  bellek_adres, bellek_yaz, bellek_yaz_veri, mesgul
   );

   modport slave (
      input  istek0, istek1, adres0, adres1, yaz0, yaz1, yaz_veri0, yaz_veri1,
      input  bellek_oku_veri,
      output kabul0, kabul1, yanit0, yanit1, oku_veri,
      output bellek_adres, bellek_yaz, bellek_yaz_veri, mesgul
   );
endinterface

// File: rtl/bellek_hakem.sv
// Two-requester round-robin arbiter for a single-port memory with a registered read.
// One transaction every three cycles: grant, memory access, response pulse.
module bellek_hakem #(
   parameter int                   ADRES_BIT = 32,
   parameter int                   VERI_BIT  = 32,
   parameter logic [ADRES_BIT-1:0] RST_ADRES = 32'h8000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   bellek_hakem_if.slave bus
);
   typedef enum logic [1:0] {
      BOS    = 2'd0,
      ERISIM = 2'd1,
      YANIT  = 2'd2
   } durum_t;

   durum_t               r_durum,     w_durum_next;
   logic                 r_oncelik,   w_oncelik_next;
   logic                 r_secilen,   w_secilen_next;
   logic                 r_yaz_islem, w_yaz_islem_next;
   logic [ADRES_BIT-1:0] r_adres,     w_adres_next;
   logic                 r_yaz,       w_yaz_next;
   logic [VERI_BIT-1:0]  r_yaz_veri,  w_yaz_veri_next;
   logic [VERI_BIT-1:0]  r_oku_veri,  w_oku_veri_next;
   logic                 r_kabul0,    w_kabul0_next;
   logic                 r_kabul1,    w_kabul1_next;
   logic                 r_yanit0,    w_yanit0_next;
   logic                 r_yanit1,    w_yanit1_next;
   logic                 w_kazanan;

   // Contention is resolved by the pointer; a lone requester always wins.
   assign w_kazanan = (bus.istek0 && bus.istek1) ? r_oncelik : bus.istek1;

   always_comb begin
      w_durum_next     = r_durum;
      w_oncelik_next   = r_oncelik;
      w_secilen_next   = r_secilen;
      w_yaz_islem_next = r_yaz_islem;
      w_adres_next     = r_adres;
      w_yaz_next       = r_yaz;
      w_yaz_veri_next  = r_yaz_veri;
      w_oku_veri_next  = r_oku_veri;
      w_kabul0_next    = 1'b0;
      w_kabul1_next    = 1'b0;
      w_yanit0_next    = 1'b0;
      w_yanit1_next    = 1'b0;

      case (r_durum)
         BOS: begin
            if (bus.istek0 || bus.istek1) begin
               w_adres_next     = w_kazanan ? bus.adres1    : bus.adres0;
               w_yaz_next       = w_kazanan ? bus.yaz1      : bus.yaz0;
               w_yaz_veri_next  = w_kazanan ? bus.yaz_veri1 : bus.yaz_veri0;
               w_yaz_islem_next = w_kazanan ? bus.yaz1      : bus.yaz0;
               w_kabul0_next    = ~w_kazanan;
               w_kabul1_next    = w_kazanan;
               w_secilen_next   = w_kazanan;
               w_oncelik_next   = ~w_kazanan;
               w_durum_next     = ERISIM;
            end
         end
         ERISIM: begin
            w_yaz_next   = 1'b0;
            w_durum_next = YANIT;
         end
         YANIT: begin
            // Registered memory read: data for the ERISIM address is on the bus now.
            if (!r_yaz_islem) begin
               w_oku_veri_next = bus.bellek_oku_veri;
            end
            w_yanit0_next = ~r_secilen;
            w_yanit1_next = r_secilen;
            w_durum_next  = BOS;
         end
         default: begin
            w_yaz_next   = 1'b0;
            w_durum_next = BOS;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_durum     <= BOS;
         r_oncelik   <= 1'b0;
         r_secilen   <= 1'b0;
         r_yaz_islem <= 1'b0;
         r_adres     <= RST_ADRES;
         r_yaz       <= 1'b0;
         r_yaz_veri  <= '0;
         r_oku_veri  <= '0;
         r_kabul0    <= 1'b0;
         r_kabul1    <= 1'b0;
         r_yanit0    <= 1'b0;
         r_yanit1    <= 1'b0;
      end else begin
         r_durum     <= w_durum_next;
         r_oncelik   <= w_oncelik_next;
         r_secilen   <= w_secilen_next;
         r_yaz_islem <= w_yaz_islem_next;
         r_adres     <= w_adres_next;
         r_yaz       <= w_yaz_next;
         r_yaz_veri  <= w_yaz_veri_next;
         r_oku_veri  <= w_oku_veri_next;
         r_kabul0    <= w_kabul0_next;
         r_kabul1    <= w_kabul1_next;
         r_yanit0    <= w_yanit0_next;
         r_yanit1    <= w_yanit1_next;
      end
   end

   assign bus.kabul0          = r_kabul0;
   assign bus.kabul1          = r_kabul1;
   assign bus.yanit0          = r_yanit0;
   assign bus.yanit1          = r_yanit1;
   assign bus.oku_veri        = r_oku_veri;
   assign bus.bellek_adres    = r_adres;
   assign bus.bellek_yaz      = r_yaz;
   assign bus.bellek_yaz_veri = r_yaz_veri;
   assign bus.mesgul          = (r_durum != BOS);
endmodule

// File: tb/tb_bellek_hakem.sv
// Randomised bench for bellek_hakem: two request generators, a registered-read memory,
// and a transaction-level schedule of expected grants, responses and port values.
module tb_bellek_hakem;
   localparam logic [31:0] RST_ADRES = 32'h8000_0000;
   localparam int          NC        = 2048;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bellek_hakem_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

   bellek_hakem #(
      .ADRES_BIT(32),
      .VERI_BIT (32),
      .RST_ADRES(RST_ADRES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int n_test = 0;
   int n_hata = 0;
   int t      = 0;

   task automatic check(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      n_test++;
      if (gozlenen !== beklenen) begin
         n_hata++;
         $display("FAIL %s cycle %0d: got %h expected %h", etiket, t, gozlenen, beklenen);
      end
   endtask

   // Memory model: 16 words indexed by address bits [5:2], read data one cycle late.
   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];

   function automatic logic [31:0] ilk_deger(input int i);
      return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= ilk_deger(i);
         bus.bellek_oku_veri <= '0;
      end else begin
         if (bus.bellek_yaz) mem[bus.bellek_adres[5:2]] <= bus.bellek_yaz_veri;
         bus.bellek_oku_veri <= mem[bus.bellek_adres[5:2]];
      end
   end

   // Pending requests per requester.
   bit          pend    [2];
   logic [31:0] q_adres [2];
   logic [31:0] q_veri  [2];
   bit          q_yaz   [2];

   // Expected events scheduled by absolute cycle number.
   int          ev_grant [NC];
   int          ev_yanit [NC];
   bit          ev_write [NC];
   bit          ev_read  [NC];
   bit          ev_busy  [NC];
   logic [31:0] ev_addr  [NC];
   logic [31:0] ev_wdata [NC];
   logic [31:0] ev_rdata [NC];

   int          free_at = 0;
   bit          rr      = 1'b0;
   logic [31:0] cur_adres, cur_wdata, cur_oku;

   task automatic model_temizle(input int bas);
      for (int k = bas; k < NC; k++) begin
         ev_grant[k] = -1; ev_yanit[k] = -1;
         ev_write[k] = 1'b0; ev_read[k] = 1'b0; ev_busy[k] = 1'b0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = ilk_deger(i);
      free_at   = 0;
      rr        = 1'b0;
      cur_adres = RST_ADRES;
      cur_wdata = '0;
      cur_oku   = '0;
   endtask

   task automatic yeni_istek(input int i);
      pend[i]    = 1'b1;
      q_adres[i] = $urandom();
      q_veri[i]  = $urandom();
      q_yaz[i]   = ($urandom_range(0, 2) == 0);
   endtask

   task automatic sur();
      bus.istek0 = pend[0]; bus.adres0 = q_adres[0]; bus.yaz0 = q_yaz[0]; bus.yaz_veri0 = q_veri[0];
      bus.istek1 = pend[1]; bus.adres1 = q_adres[1]; bus.yaz1 = q_yaz[1]; bus.yaz_veri1 = q_veri[1];
   endtask

   // Round robin at transaction level: an idle arbiter grants next cycle, busy for 3 cycles.
   task automatic model_adim();
      int w;
      int g;
      int idx;
      if (t >= free_at && (pend[0] || pend[1])) begin
         w   = (pend[0] && pend[1]) ? int'(rr) : (pend[1] ? 1 : 0);
         g   = t + 1;
         idx = int'(q_adres[w][5:2]);
         ev_grant[g] = w;
         ev_write[g] = q_yaz[w];
         ev_addr[g]  = q_adres[w];
         ev_wdata[g] = q_veri[w];
         ev_busy[g]  = 1'b1;
         ev_busy[g+1] = 1'b1;
         ev_yanit[g+2] = w;
         ev_read[g+2]  = !q_yaz[w];
         ev_rdata[g+2] = ref_mem[idx];
         if (q_yaz[w]) ref_mem[idx] = q_veri[w];
         free_at = t + 3;
         rr      = (w == 0);
         pend[w] = 1'b0;
      end
   endtask

   task automatic cevrim_kontrol();
      if (ev_grant[t] >= 0) begin
         cur_adres = ev_addr[t];
         cur_wdata = ev_wdata[t];
      end
      if (ev_yanit[t] >= 0 && ev_read[t]) cur_oku = ev_rdata[t];
      check("kabul0",          {31'b0, bus.kabul0},     {31'b0, ev_grant[t] == 0});
      check("kabul1",          {31'b0, bus.kabul1},     {31'b0, ev_grant[t] == 1});
      check("yanit0",          {31'b0, bus.yanit0},     {31'b0, ev_yanit[t] == 0});
      check("yanit1",          {31'b0, bus.yanit1},     {31'b0, ev_yanit[t] == 1});
      check("bellek_yaz",      {31'b0, bus.bellek_yaz}, {31'b0, ev_grant[t] >= 0 && ev_write[t]});
      check("bellek_adres",    bus.bellek_adres,        cur_adres);
      check("bellek_yaz_veri", bus.bellek_yaz_veri,     cur_wdata);
      check("oku_veri",        bus.oku_veri,            cur_oku);
      check("mesgul",          {31'b0, bus.mesgul},     {31'b0, ev_busy[t]});
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must settle before any clock edge.
   task automatic sifirla();
      #2 rst_n = 1'b0;
      #1;
      check("rst_bellek_adres", bus.bellek_adres, RST_ADRES);
      check("rst_bellek_yaz",   {31'b0, bus.bellek_yaz}, 32'd0);
      check("rst_yaz_veri",     bus.bellek_yaz_veri, 32'd0);
      check("rst_oku_veri",     bus.oku_veri, 32'd0);
      check("rst_darbeler",     {28'b0, bus.kabul0, bus.kabul1, bus.yanit0, bus.yanit1}, 32'd0);
      check("rst_mesgul",       {31'b0, bus.mesgul}, 32'd0);
      model_temizle(t);
      repeat (2) begin
         @(posedge clk);
         t++;
      end
      #3 rst_n = 1'b1;
   endtask

   task automatic calistir(input int n, input int p0, input int p1, input bit yazda_rst);
      bit yapildi = 1'b0;
      for (int k = 0; k < n; k++) begin
         cevrim_kontrol();
         if (yazda_rst && !yapildi && ev_grant[t] >= 0 && ev_write[t]) begin
            sifirla();
            yapildi = 1'b1;
         end
         if (!pend[0] && $urandom_range(0, 99) < p0) yeni_istek(0);
         if (!pend[1] && $urandom_range(0, 99) < p1) yeni_istek(1);
         sur();
         model_adim();
         @(posedge clk);
         #1;
         t++;
      end
      if (yazda_rst) check("yazda_rst_yapildi", {31'b0, yapildi}, 32'd1);
   endtask

   initial begin
      model_temizle(0);
      yeni_istek(0);
      yeni_istek(1);
      sur();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      calistir(12,  100, 100, 1'b0);
      calistir(300, 30,  30,  1'b0);
      sifirla();
      calistir(300, 30,  40,  1'b1);
      calistir(150, 0,   50,  1'b0);
      calistir(150, 80,  80,  1'b0);

      $display("[TB] %0d tests run, %0d failed", n_test, n_hata);
      $finish;
   end
endmodule
